fir4_feeder: RTL and testbench

Upstream sample feeder for the shared-multiplier 4-tap FIR (`fir4_b`). It accepts an 8-bit sample stream through a valid/ready handshake and buffers it in a small FIFO. It owns the coefficient bank and issues one `start` pulse per sample to the FIR, then waits for that FIR's `done` pulse before issuing the next. A watchdog recovers if `done` never arrives.

---
 rtl/fir4_feeder.sv | 158 +++++++++++++++
 tb/tb_fir4_feeder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir4_feeder.sv
// Sample feeder for the shared-multiplier 4-tap FIR: buffers samples in a FIFO and
// issues one start per sample. It holds the coefficient bank and runs a done watchdog.
module fir4_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     flush,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_addr,
    input  logic [7:0]               cfg_data,
    output logic [7:0]               h0,
    output logic [7:0]               h1,
    output logic [7:0]               h2,
    output logic [7:0]               h3,
    output logic                     fir_start,
    output logic [7:0]               fir_x,
    input  logic                     fir_done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issued_cnt,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            fir_start_reg;
    logic [7:0]      fir_x_reg;
    logic [15:0]     issued_reg;
    logic            timeout_reg;
    logic [7:0]      mem [DEPTH];
    logic [7:0]      coef [4];

    logic push, issue, abort, done_eff;

    assign in_ready = (count_reg < CW'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    // A done arriving while start is still high belongs to no issued sample.
    assign done_eff = fir_done && !fir_start_reg;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        issue      = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0 && !flush) begin
                    issue      = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_eff) begin
                    // The entries being flushed are never issued, even on a done edge.
                    if (count_reg != '0 && !flush) begin
                        issue = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (issue) begin
            timer_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            fir_start_reg <= 1'b0;
            fir_x_reg     <= 8'd0;
            issued_reg    <= 16'd0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            fir_start_reg <= issue;
            if (issue) begin
                fir_x_reg  <= mem[rd_ptr_reg];
                issued_reg <= issued_reg + 16'd1;
            end
            if (abort) begin
                timeout_reg <= 1'b1;
            end
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (issue) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                case ({push, issue})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Storage array kept free of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_coef
        logic [7:0] coef_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                coef_reg <= (gi == 0) ? 8'd1 : 8'd0;
            end else if (cfg_we && cfg_addr == 2'(gi)) begin
                coef_reg <= cfg_data;
            end
        end
        assign coef[gi] = coef_reg;
    end

    assign h0          = coef[0];
    assign h1          = coef[1];
    assign h2          = coef[2];
    assign h3          = coef[3];
    assign fir_start   = fir_start_reg;
    assign fir_x       = fir_x_reg;
    assign fifo_count  = count_reg;
    assign issued_cnt  = issued_reg;
    assign timeout_err = timeout_reg;
endmodule

// File: tb/tb_fir4_feeder.sv
// Bench for fir4_feeder: behavioural 4-tap FIR attached, issue order and results
// checked against a scoreboard, plus hand-built timeout, flush and reset sequences.
module tb_fir4_feeder;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              flush;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [7:0]        cfg_data;
    logic signed [7:0] h0, h1, h2, h3;
    logic              fir_start;
    logic signed [7:0] fir_x;
    logic              fir_done;
    logic [3:0]        fifo_count;
    logic [15:0]       issued_cnt;
    logic              timeout_err;

    fir4_feeder #(.DEPTH(DEPTH), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .h0(h0), .h1(h1), .h2(h2), .h3(h3),
        .fir_start(fir_start), .fir_x(fir_x), .fir_done(fir_done),
        .fifo_count(fifo_count), .issued_cnt(issued_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int sb[$];
    int y_exp[$];
    int hist_q[$];
    int coef_m[4] = '{1, 0, 0, 0};
    logic no_done = 1'b0;
    logic chk_gap = 1'b0;
    logic have_prev = 1'b0;
    int   prev_cyc = 0;
    int   cyc = 0;
    int   full_seen = 0;

    // FIR model: latches x and coefficients on start, pulses done in the cycle after E+5.
    int       f_y, fx0, fx1, fx2;
    logic [2:0] fcnt;
    logic     fdone;
    assign fir_done = fdone;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= 3'd0; fdone <= 1'b0; f_y <= 0; fx0 <= 0; fx1 <= 0; fx2 <= 0;
        end else begin
            fdone <= 1'b0;
            if (fir_start) begin
                fcnt <= 3'd4;
                f_y  <= int'(h0) * int'(fir_x) + int'(h1) * fx0 + int'(h2) * fx1 + int'(h3) * fx2;
                fx0  <= int'(fir_x);
                fx1  <= fx0;
                fx2  <= fx1;
            end else if (fcnt != 3'd0) begin
                fcnt <= fcnt - 3'd1;
                if (fcnt == 3'd1 && !no_done) fdone <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int golden(input int x);
        int y = coef_m[0] * x;
        for (int i = 0; i < hist_q.size() && i < 3; i++) y += coef_m[i + 1] * hist_q[i];
        return y;
    endfunction

    // Monitor: pops the scoreboard on every start, checks FIR results on every done.
    initial begin
        int xe;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && fir_start) begin
                if (sb.size() == 0) begin
                    chk("spurious_start", 1, 0);
                end else begin
                    xe = sb.pop_front();
                    $display("issue x=%0d cnt=%0d", fir_x, issued_cnt);
                    chk("fir_x", int'(fir_x), xe);
                    if (!no_done) y_exp.push_back(golden(xe));
                    hist_q.push_front(xe);
                    if (hist_q.size() > 3) void'(hist_q.pop_back());
                    if (chk_gap) begin
                        if (have_prev) chk("start_gap", cyc - prev_cyc, 6);
                        have_prev = 1'b1;
                        prev_cyc  = cyc;
                    end
                end
            end
            if (rst_n && fir_done) begin
                if (y_exp.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    $display("result y=%0d", f_y);
                    chk("fir_y", f_y, y_exp.pop_front());
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 8'(s);
        while (!in_ready && n < 100) begin
            chk("full_ready", int'(fifo_count), DEPTH);
            full_seen++;
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("push_timeout", 0, 1);
        else sb.push_back(s);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 2'(a);
        cfg_data = 8'(d);
        @(negedge clk);
        cfg_we    = 1'b0;
        coef_m[a] = d;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || y_exp.size() != 0 || fifo_count != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!fir_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("start_timeout", 0, 1);
    endtask

    typedef struct {
        int addr;
        int data;
        int e0, e1, e2, e3;
    } cfg_vec_t;

    initial begin
        cfg_vec_t tbl[4];
        int n;
        tbl[0] = '{1,  2, 1, 2,  0, 0};
        tbl[1] = '{2, -1, 1, 2, -1, 0};
        tbl[2] = '{3,  4, 1, 2, -1, 4};
        tbl[3] = '{0,  3, 3, 2, -1, 4};

        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h55; flush = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_start", int'(fir_start), 0);
        chk("rst_h0", int'(h0), 1);
        chk("rst_h1", int'(h1), 0);
        chk("rst_h3", int'(h3), 0);
        chk("rst_tmo", int'(timeout_err), 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(in_ready), 1);

        // Single sample with the identity filter: start two edges after the push.
        in_valid = 1'b1; in_data = 8'd5; sb.push_back(5);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_p0", int'(fir_start), 0);
        chk("lat_cnt", int'(fifo_count), 1);
        @(negedge clk);
        chk("lat_p1", int'(fir_start), 1);
        drain();
        chk("single_issued", int'(issued_cnt), 1);
        chk("single_count", int'(fifo_count), 0);

        for (int i = 0; i < 4; i++) begin
            cfg_write(tbl[i].addr, tbl[i].data);
            chk("cfg_h0", int'(h0), tbl[i].e0);
            chk("cfg_h1", int'(h1), tbl[i].e1);
            chk("cfg_h2", int'(h2), tbl[i].e2);
            chk("cfg_h3", int'(h3), tbl[i].e3);
        end

        // Burst of 12 back-to-back samples into an 8-deep FIFO.
        chk_gap = 1'b1; have_prev = 1'b0; full_seen = 0;
        for (int s = -7; s <= 4; s++) push(s);
        drain();
        chk_gap = 1'b0;
        chk("burst_full_seen", int'(full_seen > 0), 1);
        chk("burst_issued", int'(issued_cnt), 13);

        // Watchdog: FIR never answers.
        no_done = 1'b1;
        push(100);
        push(-100);
        wait_start();
        repeat (14) @(negedge clk);
        chk("tmo_early", int'(timeout_err), 0);
        @(negedge clk);
        chk("tmo_set", int'(timeout_err), 1);
        chk("tmo_nostart", int'(fir_start), 0);
        @(negedge clk);
        chk("tmo_reissue", int'(fir_start), 1);
        repeat (20) @(negedge clk);
        chk("tmo_issued", int'(issued_cnt), 15);
        chk("tmo_sticky", int'(timeout_err), 1);
        no_done = 1'b0;

        // Flush with five entries queued while the FIR is busy.
        for (int s = 10; s <= 15; s++) push(s);
        chk("flush_pre_count", int'(fifo_count), 5);
        flush = 1'b1;
        #1;
        chk("flush_ready", int'(in_ready), 0);
        @(negedge clk);
        flush = 1'b0;
        sb.delete();
        chk("flush_count", int'(fifo_count), 0);
        drain();
        chk("flush_issued", int'(issued_cnt), 16);

        // Coefficient write mid-op, then reset mid-op.
        push(20);
        wait_start();
        @(negedge clk);
        cfg_write(2, -3);
        chk("cfg_mid_h2", int'(h2), -3);
        push(30);
        push(40);
        n = 0;
        while (issued_cnt != 16'd19 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_issued", int'(issued_cnt), 19);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_start", int'(fir_start), 0);
        chk("mrst_x", int'(fir_x), 0);
        chk("mrst_h0", int'(h0), 1);
        chk("mrst_h2", int'(h2), 0);
        chk("mrst_count", int'(fifo_count), 0);
        chk("mrst_issued", int'(issued_cnt), 0);
        chk("mrst_tmo", int'(timeout_err), 0);
        sb.delete(); y_exp.delete(); hist_q.delete();
        coef_m = '{1, 0, 0, 0};
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(7);
        drain();
        chk("post_issued", int'(issued_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
